// File: rtl/fxp2float_pipe.sv
// Three-stage, multi-lane signed fixed-point to IEEE-754 binary32 converter.
// Define FXP2FLOAT_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fxp2float_pipe #(
  parameter int WOI   = 1,
  parameter int WOF   = 7,
  parameter int LANES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*(WOI+WOF)-1:0]    in_fxp,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*32-1:0]           out_fp32,
  output logic [LANES-1:0]              out_inexact,
  output logic [31:0]                   out_count
);

  localparam int         W     = WOI + WOF;
  localparam logic [7:0] EBIAS = 8'(127 - WOF);
  localparam logic [4:0] WM1   = 5'(W - 1);

  if (W < 2 || W > 32) begin : g_w_check
    $error("fxp2float_pipe: WOI+WOF must lie in 2..32");
  end

  function automatic logic [W-1:0] f_abs(input logic [W-1:0] r);
    return r[W-1] ? (~r + W'(1)) : r;
  endfunction

  function automatic logic [4:0] f_lead(input logic [W-1:0] m);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      if (m[i]) p = 5'(i);
    return p;
  endfunction

  // The implicit one is dropped here; only the bits below it travel on.
  function automatic logic [W-2:0] f_norm(
    input logic [W-1:0] m,
    input logic [4:0]   p
  );
    return (W-1)'(m << (WM1 - p));
  endfunction

  function automatic logic [32:0] f_pack(
    input logic         sgn,
    input logic         zero,
    input logic [4:0]   p,
    input logic [W-2:0] norm
  );
    logic [62:0] ext;
    logic [22:0] frac;
    logic        g;
    logic        st;
    logic [7:0]  e;
`ifdef FXP2FLOAT_RNE_EN
    logic [23:0] sum;
`endif
    ext  = 63'(norm) << (64 - W);
    frac = ext[62:40];
    g    = ext[39];
    st   = |ext[38:0];
    e    = 8'(p) + EBIAS;
`ifdef FXP2FLOAT_RNE_EN
    sum  = {1'b0, frac} + 24'(g & (st | frac[0]));
    frac = sum[22:0];
    e    = e + 8'(sum[23]);
`endif
    if (zero) return '0;
    return {g | st, sgn, e, frac};
  endfunction

  logic v1_q, v2_q, v3_q;
  logic acc1, acc2, acc3;

  logic [LANES-1:0]             s1_sgn_q, s1_sgn_d;
  logic [LANES-1:0]             s1_zero_q, s1_zero_d;
  logic [LANES-1:0][W-1:0]      s1_mag_q, s1_mag_d;
  logic [LANES-1:0]             s2_sgn_q, s2_zero_q;
  logic [LANES-1:0][4:0]        s2_p_q, s2_p_d;
  logic [LANES-1:0][W-2:0]      s2_norm_q, s2_norm_d;
  logic [LANES*32-1:0]          fp_q, fp_d;
  logic [LANES-1:0]             ix_q, ix_d;
  logic [31:0]                  cnt_q, cnt_d;

  assign acc3     = !v3_q | out_ready;
  assign acc2     = !v2_q | acc3;
  assign acc1     = !v1_q | acc2;
  assign in_ready = acc1 & !rst;

  assign out_valid   = v3_q;
  assign out_fp32    = fp_q;
  assign out_inexact = ix_q;
  assign out_count   = cnt_q;
  assign cnt_d       = cnt_q + 32'(v3_q & out_ready);

  always_comb begin
    s1_sgn_d  = '0;
    s1_zero_d = '0;
    s1_mag_d  = '0;
    s2_p_d    = '0;
    s2_norm_d = '0;
    fp_d      = '0;
    ix_d      = '0;
    for (int k = 0; k < LANES; k++) begin
      s1_sgn_d[k]  = in_fxp[k*W+W-1];
      s1_zero_d[k] = (in_fxp[k*W +: W] == '0);
      s1_mag_d[k]  = f_abs(in_fxp[k*W +: W]);
      s2_p_d[k]    = f_lead(s1_mag_q[k]);
      s2_norm_d[k] = f_norm(s1_mag_q[k], s2_p_d[k]);
      {ix_d[k], fp_d[k*32 +: 32]} =
        f_pack(s2_sgn_q[k], s2_zero_q[k], s2_p_q[k], s2_norm_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      fp_q  <= '0;
      ix_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (acc1) v1_q <= in_valid;
      if (acc2) v2_q <= v1_q;
      if (acc3) v3_q <= v2_q;
      if (acc3 & v2_q) begin
        fp_q <= fp_d;
        ix_q <= ix_d;
      end
      cnt_q <= cnt_d;
    end
  end

  // Payload registers need no reset; their valid bits gate them.
  always_ff @(posedge clk) begin
    if (acc1 & in_valid) begin
      s1_sgn_q  <= s1_sgn_d;
      s1_zero_q <= s1_zero_d;
      s1_mag_q  <= s1_mag_d;
    end
    if (acc2 & v1_q) begin
      s2_sgn_q  <= s1_sgn_q;
      s2_zero_q <= s1_zero_q;
      s2_p_q    <= s2_p_d;
      s2_norm_q <= s2_norm_d;
    end
  end

endmodule

// File: doc/fxp2float_pipe.md
# fxp2float_pipe

- Streaming, pipelined converter from signed two's-complement fixed-point to IEEE-754 binary32.
- Input width and binary point are parametrised. Converts `LANES` samples in parallel under one valid/ready handshake.
- Rounding is correct, and the most-negative input is handled exactly.
- Sits between the fixed-point encoder/decoder datapath and float-domain consumers (loss/metric units, host readback), replacing the single-lane 8-bit combinational converter.

## Interface

Parameters:

- `WOI`, default 1: integer bits including sign, ≥1.
- `WOF`, default 7: fraction bits, ≥0.
- `LANES`, default 1: parallel samples per transfer, ≥1.
- Derived `W = WOI+WOF`. Elaboration error unless 2 ≤ W ≤ 32.

Ports:

- `clk` in 1: rising-edge clock; the block uses this single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid & in_ready`.
- `in_fxp` in LANES*W: lane k at bits [k*W +: W], signed, value = raw / 2^WOF.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: output beat consumed when `out_valid & out_ready`.
- `out_fp32` out LANES*32: lane k at [k*32 +: 32].
- `out_inexact` out LANES: lane k set if rounding discarded nonzero bits.
- `out_count` out 32: number of output beats consumed; wraps modulo 2^32.

## Operation

Per lane:

- **Zero.** Zero input produces `0x00000000` (+0), and `inexact` is 0.
- **Sign and magnitude.**
  - s = raw[W-1].
  - Magnitude is computed as a W-bit unsigned value, so raw = -2^(W-1) gives magnitude 2^(W-1) with no overflow.
- **Leading-one position p.** Range 0..W-1, searched across all W bits, MSB included.
- **Exponent.** e = p − WOF + 127 (8-bit).
  - Example: WOI=1, WOF=7 gives e = p+120.
  - All reachable e are normal numbers (1..158). No denormals, infinities or NaNs are ever produced.
- **Significand.** Shift the magnitude left by (W−1−p) and drop the implicit one. The top 23 bits below it form the fraction.
- **Discarded bits.** Exist only when p > 23.
  - Guard = bit p−24.
  - Sticky = OR of bits below the guard.
  - `inexact` = guard | sticky.
- **Rounding.** Per Configuration. If rounding carries out of the fraction, the fraction becomes 0 and e increments by 1.
- **Output.** `{s, e, frac}`.

Pipeline and flow control:

- **Stages.**
  - S1 registers sign, magnitude and zero flag.
  - S2 registers p and the normalised magnitude.
  - S3 applies rounding, then packs the result into the output registers.
- **Stage acceptance.**
  - Each stage has a valid bit.
  - Stage k accepts a new beat when it is empty or stage k+1 accepts this cycle.
  - S3 accepts when `!out_valid | out_ready`.
- **Ready.** `in_ready` = S1 accept, combinationally derived from `out_ready` through the chain.
- **Capacity.** Full throughput, 1 beat/cycle. Bubbles collapse. At most 3 beats are in flight.
- **Data hold.** Data in a stage is held unchanged while that stage does not advance.
- **Output stability.** `out_*` remain stable while `out_valid & !out_ready`.
- **Ordering.** Beats are never dropped, duplicated or reordered. All lanes of a beat travel together.
- **Counter.** `out_count` increments by 1 on each `out_valid & out_ready` and wraps from 0xFFFFFFFF to 0.

## Timing

- **Latency.** A beat accepted in cycle t appears on `out_valid` in cycle t+3 when unstalled.
- **Reset state.** While `rst` is high at a clock edge, all stage valids clear.
  - `out_valid`=0, `out_fp32`=0, `out_inexact`=0, `out_count`=0.
  - `in_ready`=0 during reset; it is 1 in the first cycle after reset deassertion.
- **Reset mid-operation.** In-flight beats are discarded, with no partial output afterwards.
- **Simultaneous events.** With S3 full and `out_ready`=1, a new beat may enter S1 in the same cycle that S3 retires.
- **Full pipeline.** With `out_ready`=0 and all stages full, `in_ready`=0.

## Configuration

- `FXP2FLOAT_RNE_EN` defined:
  - Round to nearest, ties to even.
  - Round up iff guard & (sticky | frac LSB).
  - Carry propagation as above.
- Not defined:
  - Truncate toward zero in magnitude; the fraction takes the top 23 bits and no carry is possible.
  - `out_inexact` is still reported.
- For W ≤ 24 both builds are bit-identical, and `inexact` is always 0.

## Test plan

1. **Default (WOI=1, WOF=7).**
   - Inputs 0x40, 0x80, 0x00, 0x01 → outputs 0x3F000000, 0xBF800000, 0x00000000, 0x3C000000.
   - Latency exactly 3 cycles.
2. **WOI=16, WOF=16, RNE.**
   - 0x01000001 → 0x43800000, inexact=1 (tie, round to even).
   - 0x01000003 → 0x43800002.
   - 0x01FFFFFF → 0x44000000 (carry into exponent).
   - 0x80000000 → 0xC7000000.
3. **Same inputs without `FXP2FLOAT_RNE_EN`.** 0x01000003 → 0x43800001; 0x01FFFFFF → 0x43FFFFFF; inexact=1 for both.
4. **Backpressure.**
   - LANES=4, continuous `in_valid`, `out_ready` low for 5 cycles.
   - Exactly 3 beats accepted, then `in_ready`=0.
   - Output held stable. After release, all beats arrive in order with no loss.
   - `out_count` equals the number of beats consumed.
5. **Reset mid-stream.**
   - Assert `rst` for 1 cycle with 3 beats in flight.
   - Next cycle: `out_valid`=0, `out_count`=0, nothing emitted until new input.
   - `in_ready`=1 after deassertion.
6. **Counter wrap.** Preload via 2^32−1 consumed beats (or force); one more consumed beat → `out_count`=0.
